// File: rtl/mult_dispatch.sv
// mult_dispatch: queues signed operand pairs, feeds them one at a time to the
// Booth multiplier over its A/B/start/ready handshake, and returns each product
// (optionally accumulated onto the previous result) on a valid/ready port.
module mult_dispatch #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_acc,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_start,
  input  logic                     mul_ready,
  input  logic [2*WIDTH-1:0]       mul_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ARM_TIMEOUT) + 1;
  localparam logic [AW:0]   FullLevel   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TimeoutLast = TW'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    BUSY,
    CAPT
  } state_e;

  logic [WIDTH-1:0]   fifoA_q [DEPTH];
  logic [WIDTH-1:0]   fifoB_q [DEPTH];
  logic [DEPTH-1:0]   fifoAcc_q;
  logic [AW-1:0]      wrPtr_q;
  logic [AW-1:0]      rdPtr_q;
  logic [AW:0]        level_q;

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic [WIDTH-1:0]   mulA_q;
  logic [WIDTH-1:0]   mulB_q;
  logic               opAcc_q;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] resData_q;
  logic               resValid_q;
  logic [2*WIDTH-1:0] accNext;

  logic push;
  logic pop;
  logic capture;
  logic drain;

  // in_ready looks only at the occupancy register, so there is no combinational
  // path from the multiplier side back to the producer.
  assign in_ready  = (level_q != FullLevel);
  assign push      = in_valid && in_ready;
  assign drain     = resValid_q && res_ready;
  assign accNext   = opAcc_q ? (acc_q + mul_out) : mul_out;

  assign level     = level_q;
  assign mul_a     = mulA_q;
  assign mul_b     = mulB_q;
  assign mul_start = (state_q == ISSUE);
  assign res_valid = resValid_q;
  assign res_data  = resData_q;

  // Operand storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoA_q[wrPtr_q]   <= in_a;
      fifoB_q[wrPtr_q]   <= in_b;
      fifoAcc_q[wrPtr_q] <= in_acc;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sequencer state and arm timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Sequencer next state: never issue while the (unresettable) multiplier is still
  // busy, and fall through to capture if ready never drops (zero-latency multiplier).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if ((level_q != '0) && mul_ready) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = ARM;
      end
      ARM: begin
        if (!mul_ready) begin
          state_d = BUSY;
        end else if (timer_q == TimeoutLast) begin
          state_d = CAPT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BUSY: begin
        if (mul_ready) state_d = CAPT;
      end
      CAPT: begin
        if (!resValid_q || res_ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands presented to the multiplier stay put from issue until the next pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mulA_q  <= '0;
      mulB_q  <= '0;
      opAcc_q <= 1'b0;
    end else if (pop) begin
      mulA_q  <= fifoA_q[rdPtr_q];
      mulB_q  <= fifoB_q[rdPtr_q];
      opAcc_q <= fifoAcc_q[rdPtr_q];
    end
  end

  // Result register and accumulator; a capture may replace a result being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
    end else if (capture) begin
      acc_q      <= accNext;
      resData_q  <= accNext;
      resValid_q <= 1'b1;
    end else if (drain) begin
      resValid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_dispatch.sv
// tb_mult_dispatch: directed bench for mult_dispatch with a behavioural Booth
// multiplier stand-in and a result scoreboard.
module tb_mult_dispatch;

  localparam int W = 32;

  bit                   clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_a;
  logic signed [W-1:0]  in_b;
  logic                 in_acc;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_start;
  logic                 mul_ready;
  bit   [2*W-1:0]       mul_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*W-1:0]       res_data;
  logic [2:0]           level;

  int vecCount;
  int missCount;
  int startCount;
  int resultCount;
  int expectCount;

  logic [63:0] sbQ [$];
  longint      expAcc;

  int          mulLat;
  bit          zeroLat;
  bit          mulBusy;
  int          busyCnt;
  logic signed [W-1:0] mA;
  logic signed [W-1:0] mB;

  logic        prevStart;
  logic        prevHold;
  logic [63:0] prevData;

  mult_dispatch #(.WIDTH(W), .DEPTH(4), .ARM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_acc    (in_acc),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .level     (level)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  assign mul_ready = !mulBusy;

  // Multiplier stand-in: no reset, drops ready the cycle after start and holds the
  // product stable while idle; zeroLat mode answers instantly without dropping ready.
  always @(posedge clk) begin
    if (mul_start) begin
      mA <= $signed(mul_a);
      mB <= $signed(mul_b);
      if (zeroLat) begin
        mul_out <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
      end else begin
        mulBusy <= 1'b1;
        busyCnt <= mulLat;
      end
    end else if (mulBusy) begin
      if (busyCnt == 0) begin
        mulBusy <= 1'b0;
        mul_out <= 64'(longint'(mA) * longint'(mB));
      end else begin
        busyCnt <= busyCnt - 1;
      end
    end
  end

  // Generic comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: start pulses must be single-cycle and only issued
  // while the multiplier is ready, held results must not move, and every accepted
  // result is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_start) begin
        startCount++;
        checkOutput("start_ready", {63'b0, mul_ready}, 64'd1);
        checkOutput("start_single", {63'b0, prevStart}, 64'd0);
      end
      if (prevHold) begin
        checkOutput("hold_valid", {63'b0, res_valid}, 64'd1);
        checkOutput("hold_data", res_data, prevData);
      end
      if (res_valid && res_ready) begin
        resultCount++;
        if (sbQ.size() == 0) begin
          vecCount++;
          missCount++;
          $error("[TB] FAIL extra_result observed=%0h expected=none", res_data);
        end else begin
          checkOutput("result", res_data, sbQ.pop_front());
        end
      end
      prevHold  = res_valid && !res_ready;
      prevData  = res_data;
      prevStart = mul_start;
    end else begin
      prevHold  = 1'b0;
      prevStart = 1'b0;
    end
  end

  // Push one operand pair (waiting a bounded time for space) and, when keep is set,
  // record the expected result computed from the bench's own accumulator model.
  task automatic applyStimulus(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                               input logic acc, input bit keep);
    int guard;
    longint prod;
    guard = 0;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("push_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    if (keep) begin
      prod   = longint'(a) * longint'(b);
      expAcc = acc ? (expAcc + prod) : prod;
      sbQ.push_back(64'(expAcc));
      expectCount++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard has been emptied by the monitor.
  task automatic waitDrain(input string tag);
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 600) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_drain"}, 64'(sbQ.size()), 64'd0);
  endtask

  // Directed sequence: reset, plain products, accumulate chain, back-pressure,
  // toggled result ready, reset mid-operation, zero-latency multiplier.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = 1'b0;
    res_ready = 1'b0;
    mulLat    = 5;
    zeroLat   = 1'b0;
    expAcc    = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("rst_res_data", res_data, 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_mul_start", {63'b0, mul_start}, 64'd0);
    checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
    checkOutput("rst_mul_b", 64'(mul_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Test 1: simple products, start latency and one pulse per op
    res_ready = 1'b1;
    applyStimulus(32'sd4848, 32'sd5151, 1'b0, 1'b1);
    checkOutput("t1_start_early", {63'b0, mul_start}, 64'd0);
    @(posedge clk); #1;
    checkOutput("t1_start_lat", {63'b0, mul_start}, 64'd1);
    checkOutput("t1_mul_a", 64'(mul_a), 64'd4848);
    checkOutput("t1_mul_b", 64'(mul_b), 64'd5151);
    waitDrain("t1a");
    applyStimulus(32'sd11, 32'sd7, 1'b0, 1'b1);
    waitDrain("t1b");
    checkOutput("t1_start_count", 64'(startCount), 64'd2);

    // Test 2: signed operands and accumulate
    mulLat = 3;
    applyStimulus(-32'sd2838594, 32'sd74, 1'b0, 1'b1);
    applyStimulus(-32'sd2, -32'sd7, 1'b1, 1'b1);
    applyStimulus(32'sd100, -32'sd89, 1'b0, 1'b1);
    waitDrain("t2");

    // Test 3: back-pressure fills the FIFO, results held, then released in order
    mulLat    = 8;
    res_ready = 1'b0;
    applyStimulus(32'sd1, 32'sd2, 1'b0, 1'b1);
    applyStimulus(32'sd3, 32'sd4, 1'b1, 1'b1);
    applyStimulus(-32'sd5, 32'sd6, 1'b1, 1'b1);
    applyStimulus(32'sd7, -32'sd8, 1'b0, 1'b1);
    applyStimulus(32'sd9, 32'sd10, 1'b1, 1'b1);
    checkOutput("t3_level_full", 64'(level), 64'd4);
    checkOutput("t3_in_ready_full", {63'b0, in_ready}, 64'd0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("t3_level_held", 64'(level), 64'd3);
    checkOutput("t3_res_valid_held", {63'b0, res_valid}, 64'd1);
    checkOutput("t3_res_data_held", res_data, sbQ[0]);
    res_ready = 1'b1;
    waitDrain("t3");

    // Test 4: result ready toggling every cycle while results stream out
    mulLat    = 1;
    res_ready = 1'b0;
    applyStimulus(32'sd123456, -32'sd654321, 1'b0, 1'b1);
    applyStimulus(32'sd1000, 32'sd1000, 1'b1, 1'b1);
    applyStimulus(-32'sd77, -32'sd88, 1'b1, 1'b1);
    applyStimulus(32'sd2147483647, 32'sd2147483647, 1'b0, 1'b1);
    for (int i = 0; i < 300 && sbQ.size() != 0; i++) begin
      @(posedge clk); #1;
      res_ready = ~res_ready;
    end
    checkOutput("t4_drain", 64'(sbQ.size()), 64'd0);
    res_ready = 1'b1;
    @(posedge clk); #1;

    // Test 5: reset while the multiplier is busy; the in-flight product is abandoned
    mulLat = 10;
    applyStimulus(32'sd5, 32'sd6, 1'b0, 1'b0);
    for (int i = 0; i < 20 && mul_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("t5_mult_busy", {63'b0, mul_ready}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    expAcc = 0;
    checkOutput("t5_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("t5_res_data", res_data, 64'd0);
    checkOutput("t5_level", 64'(level), 64'd0);
    checkOutput("t5_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("t5_mul_start", {63'b0, mul_start}, 64'd0);
    checkOutput("t5_mul_a", 64'(mul_a), 64'd0);
    checkOutput("t5_mul_b", 64'(mul_b), 64'd0);
    applyStimulus(32'sd0, 32'sd23875, 1'b1, 1'b1);
    applyStimulus(32'sd3, 32'sd4, 1'b1, 1'b1);
    waitDrain("t5");

    // Test 6: multiplier whose ready never drops; capture after the arm timeout
    zeroLat = 1'b1;
    applyStimulus(32'sd7, -32'sd9, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("t6_start", {63'b0, mul_start}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_not_yet", {63'b0, res_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("t6_captured", {63'b0, res_valid}, 64'd1);
    applyStimulus(32'sd2, 32'sd3, 1'b1, 1'b1);
    waitDrain("t6");

    repeat (4) @(posedge clk);
    #1;
    checkOutput("result_count", 64'(resultCount), 64'(expectCount));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
